// File: rtl/operand_stage_v_pkg.sv
// Shared opcode constants, immediate-format codes and the opcode-to-format
// decode used by the operand stage and its immediate generator.
package operand_stage_v_pkg;

    localparam logic [6:0] OP_R_TYPE = 7'h33;
    localparam logic [6:0] OP_I_IMM  = 7'h13;
    localparam logic [6:0] OP_I_LOAD = 7'h03;
    localparam logic [6:0] OP_S_TYPE = 7'h23;
    localparam logic [6:0] OP_B_TYPE = 7'h63;
    localparam logic [6:0] OP_J_JAL  = 7'h6F;
    localparam logic [6:0] OP_I_JALR = 7'h67;
    localparam logic [6:0] OP_U_LUI  = 7'h37;
    localparam logic [6:0] OP_U_AUIPC = 7'h17;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4,
        IMM_U    = 3'd5
    } imm_type_e;

    // Which immediate layout an opcode carries (JALR shares the I layout).
    function automatic imm_type_e imm_type_of(input logic [6:0] op);
        imm_type_e t;
        t = IMM_NONE;
        case (op)
            OP_I_IMM, OP_I_LOAD, OP_I_JALR: t = IMM_I;
            OP_S_TYPE:                      t = IMM_S;
            OP_B_TYPE:                      t = IMM_B;
            OP_J_JAL:                       t = IMM_J;
            OP_U_LUI, OP_U_AUIPC:           t = IMM_U;
            default:                        t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/operand_stage_v_imm_gen.sv
// Immediate generator: extracts the immediate of the selected format from the
// raw instruction word and sign-extends it to DATA_W.
module operand_stage_v_imm_gen
    import operand_stage_v_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       instr,
    input  imm_type_e         imm_type,
    output logic [DATA_W-1:0] imm
);

    logic signed [31:0] imm32;

    // Reassemble the 32-bit immediate for each encoding format.
    always_comb begin
        imm32 = '0;
        case (imm_type)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed size cast widens with sign extension when DATA_W > 32.
    assign imm = DATA_W'(imm32);

endmodule

// File: rtl/operand_stage_v.sv
// Decode-to-execute operand stage: forwarding, operand/target construction and
// a single valid/ready output register between regfile read and the ALU.
module operand_stage_v
    import operand_stage_v_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] reg1_data,
    input  logic [DATA_W-1:0] reg2_data,
    input  logic              exmem_wr,
    input  logic [4:0]        exmem_rd,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_wr,
    input  logic [4:0]        memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] operand1,
    output logic [DATA_W-1:0] operand2,
    output logic [DATA_W-1:0] s_data,
    output logic [PC_W-1:0]   target,
    output logic [6:0]        out_op,
    output logic [2:0]        out_funct3,
    output logic [4:0]        out_rd,
    output logic              illegal
);

    logic [6:0]        op;
    logic [4:0]        rs_idx   [2];
    logic [DATA_W-1:0] reg_data [2];
    logic [DATA_W-1:0] src_val  [2];
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   imm_pc;
    logic [DATA_W-1:0] pc_ext;
    logic              load;

    logic [DATA_W-1:0] operand1_next, operand2_next, s_data_next;
    logic [PC_W-1:0]   target_next;
    logic [4:0]        out_rd_next;
    logic              illegal_next;

    logic              out_valid_reg;
    logic [DATA_W-1:0] operand1_reg, operand2_reg, s_data_reg;
    logic [PC_W-1:0]   target_reg;
    logic [6:0]        out_op_reg;
    logic [2:0]        out_funct3_reg;
    logic [4:0]        out_rd_reg;
    logic              illegal_reg;

    assign op          = instr[6:0];
    assign rs_idx[0]   = instr[19:15];
    assign rs_idx[1]   = instr[24:20];
    assign reg_data[0] = reg1_data;
    assign reg_data[1] = reg2_data;

    // Per-source forwarding: x0 reads zero, the younger EX/MEM result wins over MEM/WB.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            if (FWD_EN) begin : g_fwd
                assign src_val[gi] = (rs_idx[gi] == 5'd0)                     ? '0 :
                                     (exmem_wr && (exmem_rd == rs_idx[gi])) ? exmem_data :
                                     (memwb_wr && (memwb_rd == rs_idx[gi])) ? memwb_data :
                                                                              reg_data[gi];
            end else begin : g_direct
                assign src_val[gi] = reg_data[gi];
            end
        end
    endgenerate

    operand_stage_v_imm_gen #(
        .DATA_W(DATA_W)
    ) u_imm_gen (
        .instr   (instr),
        .imm_type(imm_type_of(op)),
        .imm     (imm)
    );

    assign imm_pc = PC_W'($signed(imm));
    assign pc_ext = DATA_W'(pc);

    // Operand map: choose ALU operands, store data, target and rd by opcode.
    always_comb begin
        operand1_next = '0;
        operand2_next = '0;
        s_data_next   = '0;
        target_next   = '0;
        out_rd_next   = instr[11:7];
        illegal_next  = 1'b0;
        case (op)
            OP_R_TYPE: begin
                operand1_next = src_val[0];
                operand2_next = src_val[1];
            end
            OP_I_IMM, OP_I_LOAD: begin
                operand1_next = src_val[0];
                operand2_next = imm;
            end
            OP_S_TYPE: begin
                operand1_next = src_val[0];
                operand2_next = imm;
                s_data_next   = src_val[1];
                out_rd_next   = 5'd0;
            end
            OP_B_TYPE: begin
                operand1_next = src_val[0];
                operand2_next = src_val[1];
                target_next   = pc + imm_pc;
                out_rd_next   = 5'd0;
            end
            OP_J_JAL: begin
                operand1_next = pc_ext;
                operand2_next = DATA_W'(4);
                target_next   = pc + imm_pc;
            end
            OP_I_JALR: begin
                operand1_next = pc_ext;
                operand2_next = DATA_W'(4);
                target_next   = (PC_W'(src_val[0]) + imm_pc) & {{(PC_W-1){1'b1}}, 1'b0};
            end
            OP_U_LUI: begin
                operand2_next = imm;
            end
            OP_U_AUIPC: begin
                operand1_next = pc_ext;
                operand2_next = imm;
            end
            default: begin
                illegal_next = 1'b1;
                out_rd_next  = 5'd0;
            end
        endcase
    end

    assign in_ready = !out_valid_reg || out_ready;
    assign load     = in_valid && in_ready;

    // Output slot: reset clears everything, flush only drops valid, else load or drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            operand1_reg   <= '0;
            operand2_reg   <= '0;
            s_data_reg     <= '0;
            target_reg     <= '0;
            out_op_reg     <= '0;
            out_funct3_reg <= '0;
            out_rd_reg     <= '0;
            illegal_reg    <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (load) begin
            out_valid_reg  <= 1'b1;
            operand1_reg   <= operand1_next;
            operand2_reg   <= operand2_next;
            s_data_reg     <= s_data_next;
            target_reg     <= target_next;
            out_op_reg     <= op;
            out_funct3_reg <= instr[14:12];
            out_rd_reg     <= out_rd_next;
            illegal_reg    <= illegal_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign operand1   = operand1_reg;
    assign operand2   = operand2_reg;
    assign s_data     = s_data_reg;
    assign target     = target_reg;
    assign out_op     = out_op_reg;
    assign out_funct3 = out_funct3_reg;
    assign out_rd     = out_rd_reg;
    assign illegal    = illegal_reg;

endmodule

// File: tb/tb_operand_stage_v.sv
// Scoreboard bench for operand_stage_v: directed RV32I vectors push expected
// results, a negedge monitor compares whatever the stage presents.
module tb_operand_stage_v;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] instr, pc, reg1_data, reg2_data;
    logic        exmem_wr, memwb_wr;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_data, memwb_data;
    logic        out_valid, out_ready;
    logic [31:0] operand1, operand2, s_data, target;
    logic [6:0]  out_op;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd;
    logic        illegal;

    typedef struct {
        logic [31:0] op1, op2, sd, tgt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    operand_stage_v dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .reg1_data(reg1_data), .reg2_data(reg2_data),
        .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand1(operand1), .operand2(operand2), .s_data(s_data), .target(target),
        .out_op(out_op), .out_funct3(out_funct3), .out_rd(out_rd), .illegal(illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] op1, input logic [31:0] op2,
                                input logic [31:0] sd, input logic [31:0] tgt,
                                input logic [6:0] op, input logic [2:0] f3,
                                input logic [4:0] rd, input logic ill);
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.sd = sd; e.tgt = tgt;
        e.op = op; e.f3 = f3; e.rd = rd; e.ill = ill;
        return e;
    endfunction

    task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                           input logic mw, input logic [4:0] mr, input logic [31:0] md);
        exmem_wr = ew; exmem_rd = er; exmem_data = ed;
        memwb_wr = mw; memwb_rd = mr; memwb_data = md;
    endtask

    // Present one instruction for one cycle and record what must come out.
    task automatic issue(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
        instr = i; pc = p; reg1_data = r1; reg2_data = r2; in_valid = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare every presented output with the scoreboard head, pop on transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb_q[0];
                chk("operand1",   operand1, e.op1);
                chk("operand2",   operand2, e.op2);
                chk("s_data",     s_data,   e.sd);
                chk("target",     target,   e.tgt);
                chk("out_op",     {25'd0, out_op}, {25'd0, e.op});
                chk("out_funct3", {29'd0, out_funct3}, {29'd0, e.f3});
                chk("out_rd",     {27'd0, out_rd}, {27'd0, e.rd});
                chk("illegal",    {31'd0, illegal}, {31'd0, e.ill});
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    $display("txn op=%02h rd=%0d op1=%08h op2=%08h sd=%08h tgt=%08h ill=%0d",
                             out_op, out_rd, operand1, operand2, s_data, target, illegal);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; pc = '0; reg1_data = '0; reg2_data = '0;
        set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        chk("rst_operand1",  operand1, 32'd0);
        chk("rst_operand2",  operand2, 32'd0);
        chk("rst_target",    target, 32'd0);
        chk("rst_illegal",   {31'd0, illegal}, 32'd0);
        @(posedge clk); #1;

        // addi x1,x2,-5 ; sw x3,8(x4)
        issue(32'hFFB10093, 32'h0, 32'd10, 32'd0, mk(32'd10, 32'hFFFFFFFB, 0, 0, 7'h13, 3'd0, 5'd1, 1'b0));
        issue(32'h00322423, 32'h0, 32'h100, 32'hAB, mk(32'h100, 32'd8, 32'hAB, 0, 7'h23, 3'd2, 5'd0, 1'b0));
        // add x5,x1,x1: EX/MEM beats MEM/WB, then MEM/WB alone, then x0 despite exmem_rd=0
        set_fwd(1'b1, 5'd1, 32'h11, 1'b1, 5'd1, 32'h22);
        issue(32'h001082B3, 32'h0, 32'h99, 32'h99, mk(32'h11, 32'h11, 0, 0, 7'h33, 3'd0, 5'd5, 1'b0));
        set_fwd(1'b1, 5'd2, 32'h11, 1'b1, 5'd1, 32'h22);
        issue(32'h001082B3, 32'h0, 32'h99, 32'h99, mk(32'h22, 32'h22, 0, 0, 7'h33, 3'd0, 5'd5, 1'b0));
        set_fwd(1'b1, 5'd0, 32'h55, 1'b0, 5'd1, 32'h66);
        issue(32'h001002B3, 32'h0, 32'h77, 32'h33, mk(32'h0, 32'h33, 0, 0, 7'h33, 3'd0, 5'd5, 1'b0));
        set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        // beq x1,x2,-16 ; jalr x1,0(x6) ; jal x1,+8
        issue(32'hFE2088E3, 32'h40, 32'd5, 32'd6, mk(32'd5, 32'd6, 0, 32'h30, 7'h63, 3'd0, 5'd0, 1'b0));
        issue(32'h000300E7, 32'h200, 32'h103, 32'h0, mk(32'h200, 32'd4, 0, 32'h102, 7'h67, 3'd0, 5'd1, 1'b0));
        issue(32'h008000EF, 32'h100, 32'h0, 32'h0, mk(32'h100, 32'd4, 0, 32'h108, 7'h6F, 3'd0, 5'd1, 1'b0));
        // lui x7,0x12345 ; auipc x8,0xFFFFF ; lw x9,-4(x10) ; illegal 0x7F
        issue(32'h123453B7, 32'h0, 32'h5, 32'h6, mk(32'h0, 32'h12345000, 0, 0, 7'h37, 3'd5, 5'd7, 1'b0));
        issue(32'hFFFFF417, 32'h1000, 32'h5, 32'h6, mk(32'h1000, 32'hFFFFF000, 0, 0, 7'h17, 3'd7, 5'd8, 1'b0));
        issue(32'hFFC52483, 32'h0, 32'h2000, 32'h6, mk(32'h2000, 32'hFFFFFFFC, 0, 0, 7'h03, 3'd2, 5'd9, 1'b0));
        issue(32'h00F00FFF, 32'h80, 32'h1234, 32'h5678, mk(32'h0, 32'h0, 0, 0, 7'h7F, 3'd0, 5'd0, 1'b1));
        repeat (2) @(posedge clk); #1;

        // Stall three cycles with a competing input, then flush the held instruction.
        out_ready = 1'b0;
        issue(32'hFFB10093, 32'h0, 32'd10, 32'd0, mk(32'd10, 32'hFFFFFFFB, 0, 0, 7'h13, 3'd0, 5'd1, 1'b0));
        instr = 32'h123453B7; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_held_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_keeps_op1", operand1, 32'd10);
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        out_ready = 1'b1;

        // Flush beats a simultaneous load while the slot is empty.
        instr = 32'h123453B7; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_load_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_load_op2", operand2, 32'hFFFFFFFB);

        // Reset while an instruction is held drops it and clears data.
        out_ready = 1'b0;
        issue(32'hFFC52483, 32'h0, 32'h2000, 32'h6, mk(32'h2000, 32'hFFFFFFFC, 0, 0, 7'h03, 3'd2, 5'd9, 1'b0));
        chk("held_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("reset_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_mid_op1", operand1, 32'd0);
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        out_ready = 1'b1;

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
